// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and constants for the performance monitor
package perf_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_CYC = 2'd0,
    SEL_PC  = 2'd1,
    SEL_ST  = 2'd2
  } sel_t;

  typedef enum logic [1:0] {
    BCD_IDLE  = 2'd0,
    BCD_SHIFT = 2'd1,
    BCD_LOAD  = 2'd2
  } bcd_state_t;

  localparam int BCD_MAX  = 999_999;
  localparam int BCD_BITS = 20;

  function automatic sel_t next_sel(input sel_t s);
    case (s)
      SEL_CYC: return SEL_PC;
      SEL_PC:  return SEL_ST;
      default: return SEL_CYC;
    endcase
  endfunction

endpackage

// File: rtl/perf_if.sv
// rtl/perf_if.sv - core-side inputs and display-side outputs of the performance monitor
interface perf_if;
  logic        done;
  logic [31:0] pc;
  logic        mem_write;
  logic        key_sel_n;
  logic [23:0] disp_value;
  logic [1:0]  disp_sel;
  logic        halted;

  modport master (
    output done, pc, mem_write, key_sel_n,
    input  disp_value, disp_sel, halted
  );

  modport slave (
    input  done, pc, mem_write, key_sel_n,
    output disp_value, disp_sel, halted
  );
endinterface

// File: rtl/perf_bin2bcd.sv
// rtl/perf_bin2bcd.sv - sequential double-dabble: snapshot, 20 shift cycles, 1 load cycle
module perf_bin2bcd
  import perf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [BCD_BITS-1:0] i_bin,
  output logic                o_busy,
  output logic                o_valid,
  output logic [23:0]         o_bcd
);

  bcd_state_t          r_state;
  logic [BCD_BITS-1:0] r_bin;
  logic [23:0]         r_acc;
  logic [4:0]          r_cnt;
  logic                r_busy;
  logic                r_valid;
  logic [23:0]         w_adj;

  // add-3 correction on every digit that would overflow when doubled
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < 6; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BCD_IDLE;
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        BCD_IDLE: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_bin   <= i_bin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= BCD_SHIFT;
          end
        end
        BCD_SHIFT: begin
          r_acc <= {w_adj[22:0], r_bin[BCD_BITS-1]};
          r_bin <= {r_bin[BCD_BITS-2:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(BCD_BITS - 1)) begin
            r_valid <= 1'b1;
            r_state <= BCD_LOAD;
          end
        end
        BCD_LOAD: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= BCD_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= BCD_IDLE;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_bcd   = r_acc;

endmodule

// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - cycle/PC-change/store counters frozen at end-of-program, button-selected display
// Optional PERF_BCD_EN: display 6 BCD digits via perf_bin2bcd instead of raw hex.
module perf_monitor #(
  parameter int CNT_W           = 32,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input logic   clk,
  input logic   reset,
  perf_if.slave bus
);
  import perf_pkg::*;

  localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_FULL = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic             r_halted;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_pc_cnt;
  logic [CNT_W-1:0] r_st_cnt;
  logic [31:0]      r_pc_q;
  logic             w_count_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.done) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  // the edge that first sees done is already excluded from every count
  assign w_count_en = (r_state == RUN) && !bus.done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= '0;
      r_pc_cnt    <= '0;
      r_st_cnt    <= '0;
      r_pc_q      <= '0;
    end else begin
      r_pc_q <= bus.pc;
      if (w_count_en) begin
        r_cycle_cnt <= sat_inc(r_cycle_cnt);
        if (bus.pc != r_pc_q) r_pc_cnt <= sat_inc(r_pc_cnt);
        if (bus.mem_write)    r_st_cnt <= sat_inc(r_st_cnt);
      end
    end
  end

  logic [1:0]      r_key_sync;
  logic [1:0]      r_sync_vld;
  logic            r_last;
  logic            r_key_db;
  logic            r_armed;
  logic [DB_W-1:0] r_db_run;
  sel_t            r_disp_sel;
  logic            w_sample;
  logic            w_sample_vld;
  logic [DB_W-1:0] w_run_next;
  logic            w_stable;
  logic            w_press;

  assign w_sample     = r_key_sync[1];
  assign w_sample_vld = r_sync_vld[1];
  assign w_run_next   = (r_db_run == '0 || w_sample != r_last) ? DB_W'(1) :
                        (r_db_run == DB_FULL) ? DB_FULL : r_db_run + DB_W'(1);
  assign w_stable     = w_sample_vld && (w_run_next == DB_FULL);
  // presses need a confirmed release since reset, so a key held through reset is ignored
  assign w_press      = w_stable && !w_sample && r_key_db && r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_sync <= 2'b11;
      r_sync_vld <= 2'b00;
      r_last     <= 1'b1;
      r_key_db   <= 1'b1;
      r_armed    <= 1'b0;
      r_db_run   <= '0;
      r_disp_sel <= SEL_CYC;
    end else begin
      r_key_sync <= {r_key_sync[0], bus.key_sel_n};
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      if (w_sample_vld) begin
        r_db_run <= w_run_next;
        r_last   <= w_sample;
      end
      if (w_stable) begin
        r_key_db <= w_sample;
        if (w_sample) r_armed <= 1'b1;
      end
      if (w_press) r_disp_sel <= next_sel(r_disp_sel);
    end
  end

  logic [CNT_W-1:0] w_sel_cnt;
  logic [23:0]      r_disp_value;

  always_comb begin
    w_sel_cnt = r_cycle_cnt;
    case (r_disp_sel)
      SEL_PC:  w_sel_cnt = r_pc_cnt;
      SEL_ST:  w_sel_cnt = r_st_cnt;
      default: w_sel_cnt = r_cycle_cnt;
    endcase
  end

`ifdef PERF_BCD_EN
  logic [63:0]         w_sel_wide;
  logic [BCD_BITS-1:0] w_bcd_in;
  logic                w_bcd_busy;
  logic                w_bcd_valid;
  logic [23:0]         w_bcd;

  assign w_sel_wide = 64'(w_sel_cnt);
  assign w_bcd_in   = (w_sel_wide > 64'(BCD_MAX)) ? BCD_BITS'(BCD_MAX) : BCD_BITS'(w_sel_cnt);

  perf_bin2bcd u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .i_start (!w_bcd_busy),
    .i_bin   (w_bcd_in),
    .o_busy  (w_bcd_busy),
    .o_valid (w_bcd_valid),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset)            r_disp_value <= '0;
    else if (w_bcd_valid) r_disp_value <= w_bcd;
  end
`else
  always_ff @(posedge clk) begin
    if (reset) r_disp_value <= '0;
    else       r_disp_value <= 24'(w_sel_cnt);
  end
`endif

  assign bus.disp_value = r_disp_value;
  assign bus.disp_sel   = r_disp_sel;
  assign bus.halted     = r_halted;

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - directed self-checking bench for perf_monitor (hex or PERF_BCD_EN build)
module tb_perf_monitor;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  perf_if bus();
  perf_if sat_bus();

  perf_monitor #(.CNT_W(32), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  perf_monitor #(.CNT_W(8), .DEBOUNCE_CYCLES(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press();
    bus.key_sel_n = 1'b0;
    tick(10);
    bus.key_sel_n = 1'b1;
    tick(50);
  endtask

  function automatic logic [31:0] exp_disp(input int n);
`ifdef PERF_BCD_EN
    int          v = (n > 999_999) ? 999_999 : n;
    logic [31:0] r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
`else
    logic [31:0] r = n;
    return {8'h00, r[23:0]};
`endif
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.done = 1'b0;
    bus.pc = 32'h0;
    bus.mem_write = 1'b0;
    bus.key_sel_n = 1'b1;
    sat_bus.done = 1'b0;
    sat_bus.pc = 32'h0;
    sat_bus.mem_write = 1'b0;
    sat_bus.key_sel_n = 1'b1;

    tick(2);
    check("rst_disp", {8'h0, bus.disp_value}, 32'h0);
    check("rst_sel", {30'h0, bus.disp_sel}, 32'h0);
    check("rst_halted", {31'h0, bus.halted}, 32'h0);
    check("rst_sat_disp", {8'h0, sat_bus.disp_value}, 32'h0);
    reset = 1'b0;

    // 100 counting cycles with a constant PC, then halt
    tick(100);
    bus.done = 1'b1;
    tick(1);
    check("t1_halted", {31'h0, bus.halted}, 32'h1);
    tick(50);
    check("t1_cycles", {8'h0, bus.disp_value}, exp_disp(100));
    press();
    check("t1_sel", {30'h0, bus.disp_sel}, 32'h1);
    check("t1_pc_cnt", {8'h0, bus.disp_value}, exp_disp(0));

    // reset while the display pipeline is busy
    reset = 1'b1;
    bus.done = 1'b0;
    tick(1);
    check("t2_rst_disp", {8'h0, bus.disp_value}, 32'h0);
    check("t2_rst_sel", {30'h0, bus.disp_sel}, 32'h0);
    check("t2_rst_halted", {31'h0, bus.halted}, 32'h0);
    reset = 1'b0;

    for (int k = 1; k <= 50; k++) begin
      if (k <= 10) bus.pc = 32'(4 * k);
      bus.mem_write = (k >= 47);
      tick(1);
    end
    bus.done = 1'b1;
    tick(3);
    bus.mem_write = 1'b0;
    check("t2_halted", {31'h0, bus.halted}, 32'h1);
    tick(200);
    bus.done = 1'b0;
    tick(50);
    check("t2_cycles_frozen", {8'h0, bus.disp_value}, exp_disp(50));
    check("t2_halted_sticky", {31'h0, bus.halted}, 32'h1);

    bus.key_sel_n = 1'b0;
    tick(2);
    bus.key_sel_n = 1'b1;
    tick(20);
    check("t4_glitch_sel", {30'h0, bus.disp_sel}, 32'h0);

    press();
    check("t4_sel1", {30'h0, bus.disp_sel}, 32'h1);
    check("t2_pc_cnt", {8'h0, bus.disp_value}, exp_disp(10));
    press();
    check("t4_sel2", {30'h0, bus.disp_sel}, 32'h2);
    check("t3_st_cnt", {8'h0, bus.disp_value}, exp_disp(4));
    press();
    check("t4_sel0", {30'h0, bus.disp_sel}, 32'h0);
    check("t4_cycles_again", {8'h0, bus.disp_value}, exp_disp(50));
    press();
    check("t4_sel_wrap1", {30'h0, bus.disp_sel}, 32'h1);

    // key held through reset must not count as a press
    bus.key_sel_n = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    check("hold_rst_sel_a", {30'h0, bus.disp_sel}, 32'h0);
    bus.key_sel_n = 1'b1;
    tick(20);
    check("hold_rst_sel_b", {30'h0, bus.disp_sel}, 32'h0);
    press();
    check("hold_rst_press", {30'h0, bus.disp_sel}, 32'h1);

    // 8-bit counters saturate and hold
    tick(300);
    check("t5_sat", {8'h0, sat_bus.disp_value}, exp_disp(255));
    tick(100);
    check("t5_sat_hold", {8'h0, sat_bus.disp_value}, exp_disp(255));

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1234);
    bus.done = 1'b1;
    tick(1);
    tick(43);
    check("t6_cycles_1234", {8'h0, bus.disp_value}, exp_disp(1234));
    reset = 1'b1;
    tick(1);
    check("t6_rst_disp", {8'h0, bus.disp_value}, 32'h0);
    reset = 1'b0;
    bus.done = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
